// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Holds the PC and issues in-order word requests to instruction memory. The PC of
// each accepted request is kept in a pending FIFO. Returned words are paired with
// that PC and buffered in a small output queue, which decode drains with a
// valid/stall handshake. A redirect from execute flushes the stage. Responses still
// in flight at that point are counted in `kill` and discarded when they arrive.
// The issue bound (outstanding + queued + kill < DEPTH) guarantees the output
// queue always has room for every live response.
// Optional feature: define FETCH_BYPASS_EN to let a response go straight to the
// outputs in the same cycle when the queue is empty and decode is not stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH       = 2,
  parameter logic [31:0] BUBBLE_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // PC is kept as a word address so imem_addr[1:0] is structurally zero
  logic [29:0]   pc_word;

  logic [29:0]   pend_pc [DEPTH];
  logic [AW-1:0] pend_rd;
  logic [AW-1:0] pend_wr;
  logic [CW-1:0] outstanding;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_insn [DEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [CW-1:0] q_count;

  logic [CW-1:0] kill;

  logic [CW:0]   in_use;
  logic          accept;
  logic          resp_kill;
  logic          resp_live;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  assign in_use    = {1'b0, outstanding} + {1'b0, q_count} + {1'b0, kill};
  assign imem_req  = !reset && !redirect_valid && (in_use < DEPTH_W);
  assign imem_addr = {pc_word, 2'b00};
  assign accept    = imem_req && imem_ready;

  // Responses arrive in order, so every killed word precedes any live one.
  // A response with nothing in flight is spurious and is ignored.
  assign resp_kill = imem_rvalid && (kill != '0);
  assign resp_live = imem_rvalid && (kill == '0) && (outstanding != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_live && (q_count == '0) && !stall && !redirect_valid && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_live && !bypass && !redirect_valid;
  assign pop  = (q_count != '0) && !stall;

  // Present the queue head (or the bypassed response) to decode, else a bubble
  always_comb begin
    if_valid       = 1'b0;
    if_pc          = '0;
    if_instruction = BUBBLE_INSN;
    if (!reset) begin
      if (q_count != '0) begin
        if_valid       = 1'b1;
        if_pc          = q_pc[q_rd];
        if_instruction = q_insn[q_rd];
      end else if (bypass) begin
        if_valid       = 1'b1;
        if_pc          = {pend_pc[pend_rd], 2'b00};
        if_instruction = imem_rdata;
      end
    end
  end

  // Storage arrays: written on accept/push only, contents gated by the counters
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid) begin
      if (accept) pend_pc[pend_wr] <= pc_word;
      if (push) begin
        q_pc[q_wr]   <= {pend_pc[pend_rd], 2'b00};
        q_insn[q_wr] <= imem_rdata;
      end
    end
  end

  // PC, pointers and counters; redirect flushes everything still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_word     <= RESET_PC[31:2];
      pend_rd     <= '0;
      pend_wr     <= '0;
      outstanding <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
      kill        <= '0;
    end else if (redirect_valid) begin
      pc_word     <= redirect_pc[31:2];
      pend_rd     <= '0;
      pend_wr     <= '0;
      outstanding <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
      // a response landing this cycle retires one in-flight word either way
      kill        <= kill + outstanding - CW'(resp_kill || resp_live);
    end else begin
      if (accept) begin
        pend_wr <= pend_wr + 1'b1;
        pc_word <= pc_word + 30'd1;
      end
      if (resp_live) pend_rd <= pend_rd + 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(resp_live);
      if (resp_kill) kill <= kill - 1'b1;
      if (push) q_wr <= q_wr + 1'b1;
      if (pop)  q_rd <= q_rd + 1'b1;
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized run.
// The bench holds an in-order memory model and an architectural expectation of
// the fetch stream. Every accepted request must carry the next sequential
// address since the last reset/redirect. Every instruction decode consumes must
// be the next sequential PC, carrying that address's memory word.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .BUBBLE_INSN(BUBBLE)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          consumed = 0;
  logic [31:0] exp_req;
  logic [31:0] exp_out;
  logic [31:0] last_out_pc;
  logic [31:0] prev_acc;
  logic        wrap_seen;

  logic        rst_v, stall_v, ready_v, redir_v, mem_hold, mem_fast;
  logic [31:0] redir_pc_v;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample after settling, update model
  task automatic step();
    logic        rv;
    logic [31:0] ra;
    @(negedge clk);
    rv = 1'b0;
    ra = '0;
    if (!rst_v && memq.size() > 0 && !mem_hold && memq[0].due <= cyc &&
        (mem_fast || $urandom_range(0, 2) != 0)) begin
      rv = 1'b1;
      ra = memq[0].addr;
    end
    reset          = rst_v;
    stall          = stall_v;
    imem_ready     = ready_v;
    redirect_valid = redir_v && !rst_v;
    redirect_pc    = redir_pc_v;
    imem_rvalid    = rv;
    imem_rdata     = rv ? memf(ra) : $urandom();
    #1;
    if (rst_v) begin
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_insn", if_instruction, BUBBLE);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      memq.delete();
      exp_req = RESET_PC;
      exp_out = RESET_PC;
    end else begin
      if (redirect_valid) chk("redir_no_req", 32'(imem_req), 32'd0);
      if (imem_req && imem_ready) begin
        chk("req_addr", imem_addr, exp_req);
        if (prev_acc == 32'hFFFF_FFFC && imem_addr == 32'h0) wrap_seen = 1'b1;
        prev_acc = imem_addr;
        memq.push_back('{imem_addr, cyc + 1});
        exp_req = exp_req + 32'd4;
        accepts++;
      end
      if (rv) void'(memq.pop_front());
      if (if_valid && !stall) begin
        chk("out_pc", if_pc, exp_out);
        chk("out_insn", if_instruction, memf(exp_out));
        exp_out     = exp_out + 32'd4;
        last_out_pc = if_pc;
        consumed++;
      end
      if (!if_valid) chk("bubble_insn", if_instruction, BUBBLE);
      if (redirect_valid) begin
        exp_req = {redir_pc_v[31:2], 2'b00};
        exp_out = exp_req;
      end
      chk("inflight_bound", 32'(memq.size() <= DEPTH), 32'd1);
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v   = 1'b1;
    redir_v = 1'b0;
    step();
    step();
    rst_v = 1'b0;
  endtask

  // Bounded wait for the next consumed instruction; returns all-ones on timeout
  task automatic first_out(output logic [31:0] pc);
    int c0;
    c0 = consumed;
    pc = 32'hFFFF_FFFF;
    for (int k = 0; k < 40; k++) begin
      step();
      if (consumed != c0) begin
        pc = last_out_pc;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          a0;
    int          exp_lat;
    logic [31:0] fpc;

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;
    rst_v = 1'b1; stall_v = 1'b0; ready_v = 1'b1; redir_v = 1'b0;
    redir_pc_v = '0; mem_hold = 1'b0; mem_fast = 1'b1;
    exp_req = RESET_PC; exp_out = RESET_PC; last_out_pc = '0;
    prev_acc = '0; wrap_seen = 1'b0;

    // sequential fetch from reset, first-word latency
`ifdef FETCH_BYPASS_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    do_reset();
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (if_valid && lat < 0) lat = k;
    end
    chk("first_latency", 32'(lat), 32'(exp_lat));
    for (int k = 0; k < 12; k++) step();

    // stall holds head, issue limited to DEPTH
    do_reset();
    stall_v = 1'b1;
    a0 = accepts;
    for (int k = 0; k < 5; k++) step();
    chk("stall_accepts", 32'(accepts - a0), 32'(DEPTH));
    chk("stall_head_valid", 32'(if_valid), 32'd1);
    chk("stall_head_pc", if_pc, RESET_PC);
    stall_v = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // redirect with two requests in flight
    do_reset();
    mem_hold = 1'b1;
    a0 = accepts;
    step();
    step();
    chk("two_outstanding", 32'(accepts - a0), 32'd2);
    redir_v = 1'b1; redir_pc_v = 32'h0000_0103;
    step();
    redir_v = 1'b0; mem_hold = 1'b0;
    step();
    chk("redir_next_addr", imem_addr, 32'h0000_0100);
    first_out(fpc);
    chk("redir_first_pc", fpc, 32'h0000_0100);

    // redirect in the same cycle a response returns
    do_reset();
    step();
    redir_v = 1'b1; redir_pc_v = 32'h0000_0200;
    step();
    redir_v = 1'b0;
    first_out(fpc);
    chk("redir_rvalid_first_pc", fpc, 32'h0000_0200);

    // PC wraps from the top of the address space
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFF8;
    step();
    redir_v = 1'b0;
    wrap_seen = 1'b0;
    for (int k = 0; k < 15; k++) step();
    chk("pc_wrap", 32'(wrap_seen), 32'd1);

    // reset while a request is outstanding
    do_reset();
    mem_hold = 1'b1;
    step();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0; mem_hold = 1'b0;
    first_out(fpc);
    chk("restart_pc", fpc, RESET_PC);

    // randomized traffic
    mem_fast = 1'b0;
    a0 = consumed;
    for (int k = 0; k < 3000; k++) begin
      stall_v    = ($urandom_range(0, 3) == 0);
      ready_v    = ($urandom_range(0, 3) != 0);
      redir_v    = ($urandom_range(0, 24) == 0);
      redir_pc_v = $urandom();
      rst_v      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_v = 1'b0; redir_v = 1'b0; stall_v = 1'b0; ready_v = 1'b1;
    for (int k = 0; k < 30; k++) step();
    chk("random_progress", 32'(consumed - a0 > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
